// File: rtl/mem_copy_engine.sv
// Byte-wise memory copy engine: reads one source byte, writes it to the
// destination, repeats for `length` bytes with 8-bit wrapping addresses.
module mem_copy_engine (
    input  logic       sysclk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] length,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [7:0] progress,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_writeData,
    output logic       mem_write,
    input  logic [7:0] mem_readData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;

    logic [7:0] src_q;
    logic [7:0] dst_q;
    logic [7:0] len_q;
    logic [7:0] prog_q;
    logic       done_q;
    logic       aborted_q;

    logic [7:0] src_nx;
    logic [7:0] dst_nx;
    logic [7:0] len_nx;
    logic [7:0] prog_nx;
    logic       done_nx;
    logic       aborted_nx;

    logic [7:0] prog_inc;
    logic       last_byte;

    assign prog_inc  = prog_q + 8'd1;
    assign last_byte = (prog_inc == len_q);

    assign progress = prog_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

    // State and captured-parameter registers; reset clears everything at once.
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            src_q     <= 8'h00;
            dst_q     <= 8'h00;
            len_q     <= 8'h00;
            prog_q    <= 8'h00;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state     <= state_nx;
            src_q     <= src_nx;
            dst_q     <= dst_nx;
            len_q     <= len_nx;
            prog_q    <= prog_nx;
            done_q    <= done_nx;
            aborted_q <= aborted_nx;
        end
    end

    // Next-state and memory-port decode; abort outranks completion.
    always_comb begin
        state_nx      = state;
        src_nx        = src_q;
        dst_nx        = dst_q;
        len_nx        = len_q;
        prog_nx       = prog_q;
        done_nx       = 1'b0;
        aborted_nx    = 1'b0;
        busy          = 1'b0;
        mem_addr      = 8'h00;
        mem_write     = 1'b0;
        mem_writeData = 8'h00;

        unique case (state)
            IDLE: begin
                if (start) begin
                    prog_nx = 8'h00;
                    if (length != 8'd0) begin
                        src_nx   = src_addr;
                        dst_nx   = dst_addr;
                        len_nx   = length;
                        state_nx = READ;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end

            READ: begin
                busy     = 1'b1;
                mem_addr = src_q + prog_q;
                if (abort) begin
                    state_nx   = IDLE;
                    aborted_nx = 1'b1;
                end else begin
                    state_nx = WRITE;
                end
            end

            WRITE: begin
                busy          = 1'b1;
                mem_addr      = dst_q + prog_q;
                mem_write     = 1'b1;
                mem_writeData = mem_readData;
                prog_nx       = prog_inc;
                if (abort) begin
                    state_nx   = IDLE;
                    aborted_nx = 1'b1;
                end else if (last_byte) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    state_nx = READ;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
